// File: rtl/svc_rv_soc_run_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : svc_rv_soc_run_pkg
// Description : Shared types for the svc_rv_soc run sequencer.
//               Contains the sequencer state enum, the run status codes and
//               the stop-cause priority helper.
// Ports       : none (package)
// Revision    : 1.0  initial release
// ============================================================================
package svc_rv_soc_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HOLD   = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_DONE   = 3'd4
  } run_state_t;

  localparam logic [1:0] RUN_ST_NONE    = 2'd0;
  localparam logic [1:0] RUN_ST_EBREAK  = 2'd1;
  localparam logic [1:0] RUN_ST_TRAP    = 2'd2;
  localparam logic [1:0] RUN_ST_TIMEOUT = 2'd3;

  // Stop cause with priority trap > ebreak > timeout. Only meaningful when
  // at least one stop condition is active.
  function automatic logic [1:0] f_stop_status(input logic i_trap,
                                               input logic i_ebreak);
    if (i_trap)
      return RUN_ST_TRAP;
    else if (i_ebreak)
      return RUN_ST_EBREAK;
    else
      return RUN_ST_TIMEOUT;
  endfunction

endpackage
`default_nettype wire

// File: rtl/svc_rv_soc_run_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : svc_rv_soc_run_ctrl_if
// Description : Bundle of control, SoC-side and report-stream signals of the
//               run sequencer.
//   master (sequencer): in  start, soc_ebreak, soc_trap, rpt_ready
//                       out soc_rst_n, busy, done, status[1:0],
//                           cycles[CYC_W-1:0], rpt_valid, rpt_data[7:0]
//   slave  (user side): directions reversed
// Revision    : 1.0  initial release
// ============================================================================
interface svc_rv_soc_run_ctrl_if #(
  parameter int CYC_W = 32
);
  logic             start;
  logic             soc_ebreak;
  logic             soc_trap;
  logic             soc_rst_n;
  logic             busy;
  logic             done;
  logic [1:0]       status;
  logic [CYC_W-1:0] cycles;
  logic             rpt_valid;
  logic [7:0]       rpt_data;
  logic             rpt_ready;

  modport master (
    input  start, soc_ebreak, soc_trap, rpt_ready,
    output soc_rst_n, busy, done, status, cycles, rpt_valid, rpt_data
  );

  modport slave (
    output start, soc_ebreak, soc_trap, rpt_ready,
    input  soc_rst_n, busy, done, status, cycles, rpt_valid, rpt_data
  );
endinterface
`default_nettype wire

// File: rtl/svc_rv_soc_run_ctrl_rpt_ser.sv
`default_nettype none
// ============================================================================
// Module      : svc_rv_soc_run_rpt_ser
// Description : Word-to-byte valid/ready serializer for the run report.
//               On i_load it emits {6'b0,status} followed by the cycle count
//               least-significant byte first.
//   clk, rst_n         : clock, synchronous active-low reset
//   i_load             : capture status/cycles and start a new report
//   i_status, i_cycles : report contents
//   i_ready            : downstream accepts current byte
//   o_valid, o_data    : registered byte stream
//   o_last_acc         : last byte is being accepted this cycle
// Revision    : 1.0  initial release
// ============================================================================
module svc_rv_soc_run_rpt_ser #(
  parameter int CYC_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [1:0]       i_status,
  input  logic [CYC_W-1:0] i_cycles,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [7:0]       o_data,
  output logic             o_last_acc
);

  localparam int NBYTES = CYC_W / 8 + 1;
  localparam int IDX_W  = $clog2(NBYTES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

  logic             r_valid;
  logic [7:0]       r_data;
  logic [CYC_W-1:0] r_word;
  logic [IDX_W-1:0] r_idx;
  logic             w_acc;

  assign w_acc      = r_valid && i_ready;
  assign o_last_acc = w_acc && (r_idx == IDX_LAST);
  assign o_valid    = r_valid;
  assign o_data     = r_data;

  // r_word is a shift register: its low byte is always the next byte to send
  // after the one currently presented on r_data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_data  <= 8'h00;
      r_word  <= '0;
      r_idx   <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= {6'b0, i_status};
      r_word  <= i_cycles;
      r_idx   <= '0;
    end else if (w_acc) begin
      if (r_idx == IDX_LAST) begin
        r_valid <= 1'b0;
        r_data  <= 8'h00;
      end else begin
        r_idx  <= r_idx + 1'b1;
        r_data <= r_word[7:0];
        r_word <= r_word >> 8;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/svc_rv_soc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : svc_rv_soc_run_ctrl
// Description : Run sequencer for an svc_rv_soc_sram instance. Holds the SoC
//               in reset, releases it on start, counts RUN cycles until
//               trap / ebreak / timeout, returns the SoC to reset and emits a
//               status + cycle-count byte report.
//   clk   : system clock
//   rst_n : synchronous active-low reset
//   bus   : svc_rv_soc_run_ctrl_if.master (start, soc_ebreak, soc_trap,
//           soc_rst_n, busy, done, status, cycles, rpt_valid/data/ready)
// Revision    : 1.0  initial release
// ============================================================================
module svc_rv_soc_run_ctrl
  import svc_rv_soc_run_pkg::*;
#(
  parameter int          CYC_W      = 32,
  parameter int          RST_CYCLES = 4,
  parameter int unsigned TIMEOUT    = 1048576,
  parameter int          REPORT     = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  svc_rv_soc_run_ctrl_if.master bus
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [CYC_W-1:0]  CNT_MAX   = '1;

  run_state_t        r_state;
  logic [HOLD_W-1:0] r_hold_cnt;
  logic [CYC_W-1:0]  r_run_cnt;
  logic              r_soc_rst_n;
  logic              r_busy;
  logic              r_done;
  logic [1:0]        r_status;
  logic [CYC_W-1:0]  r_cycles;

  logic              w_timeout;
  logic              w_stop;
  logic [1:0]        w_stop_status;
  logic              w_rpt_last;

  // Compare in 64 bits so a TIMEOUT wider than the counter simply never hits.
  assign w_timeout     = (TIMEOUT != 0) && (64'(r_run_cnt) == 64'(TIMEOUT));
  assign w_stop        = (r_state == ST_RUN) &&
                         (bus.soc_trap || bus.soc_ebreak || w_timeout);
  assign w_stop_status = f_stop_status(bus.soc_trap, bus.soc_ebreak);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_hold_cnt  <= '0;
      r_run_cnt   <= '0;
      r_soc_rst_n <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_status    <= RUN_ST_NONE;
      r_cycles    <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            r_state    <= ST_HOLD;
            r_hold_cnt <= '0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end

        ST_HOLD: begin
          if (r_hold_cnt == HOLD_LAST) begin
            r_state     <= ST_RUN;
            r_soc_rst_n <= 1'b1;
            r_run_cnt   <= '0;
          end else begin
            r_hold_cnt <= r_hold_cnt + 1'b1;
          end
        end

        ST_RUN: begin
          if (w_stop) begin
            // Latch the count as it stands; the stopping cycle is not counted.
            r_status    <= w_stop_status;
            r_cycles    <= r_run_cnt;
            r_soc_rst_n <= 1'b0;
            if (REPORT != 0) begin
              r_state <= ST_REPORT;
            end else begin
              r_state <= ST_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else if (r_run_cnt != CNT_MAX) begin
            r_run_cnt <= r_run_cnt + 1'b1;
          end
        end

        ST_REPORT: begin
          if (w_rpt_last) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  generate
    if (REPORT != 0) begin : g_rpt
      logic w_load;
      // Load on the stop edge using the values being latched on that edge.
      assign w_load = w_stop;

      svc_rv_soc_run_rpt_ser #(
        .CYC_W (CYC_W)
      ) u_rpt_ser (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_status   (w_stop_status),
        .i_cycles   (r_run_cnt),
        .i_ready    (bus.rpt_ready),
        .o_valid    (bus.rpt_valid),
        .o_data     (bus.rpt_data),
        .o_last_acc (w_rpt_last)
      );
    end else begin : g_no_rpt
      logic w_unused_rpt_ready;
      assign w_unused_rpt_ready = bus.rpt_ready;
      assign bus.rpt_valid      = 1'b0;
      assign bus.rpt_data       = 8'h00;
      assign w_rpt_last         = 1'b0;
    end
  endgenerate

  assign bus.soc_rst_n = r_soc_rst_n;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.status    = r_status;
  assign bus.cycles    = r_cycles;

endmodule
`default_nettype wire

// File: tb/tb_svc_rv_soc_run_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_svc_rv_soc_run_ctrl
// Description : Self-checking bench for svc_rv_soc_run_ctrl. Four instances
//               with different parameters share stimulus; only the selected
//               one is out of reset. Report bytes are predicted into a queue
//               when the stop stimulus is driven and popped on acceptance.
// Revision    : 1.0  initial release
// ============================================================================
module tb_svc_rv_soc_run_ctrl;
  import svc_rv_soc_run_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c, rst_d;
  logic tb_start, tb_ebreak, tb_trap, tb_ready;

  svc_rv_soc_run_ctrl_if #(.CYC_W(32)) if_a ();
  svc_rv_soc_run_ctrl_if #(.CYC_W(32)) if_b ();
  svc_rv_soc_run_ctrl_if #(.CYC_W(32)) if_c ();
  svc_rv_soc_run_ctrl_if #(.CYC_W(32)) if_d ();

  assign if_a.start = tb_start; assign if_a.soc_ebreak = tb_ebreak;
  assign if_a.soc_trap = tb_trap; assign if_a.rpt_ready = tb_ready;
  assign if_b.start = tb_start; assign if_b.soc_ebreak = tb_ebreak;
  assign if_b.soc_trap = tb_trap; assign if_b.rpt_ready = tb_ready;
  assign if_c.start = tb_start; assign if_c.soc_ebreak = tb_ebreak;
  assign if_c.soc_trap = tb_trap; assign if_c.rpt_ready = tb_ready;
  assign if_d.start = tb_start; assign if_d.soc_ebreak = tb_ebreak;
  assign if_d.soc_trap = tb_trap; assign if_d.rpt_ready = tb_ready;

  svc_rv_soc_run_ctrl #(.CYC_W(32), .RST_CYCLES(4), .TIMEOUT(1048576), .REPORT(1))
    dut_a (.clk(clk), .rst_n(rst_a), .bus(if_a.master));
  svc_rv_soc_run_ctrl #(.CYC_W(32), .RST_CYCLES(4), .TIMEOUT(16), .REPORT(1))
    dut_b (.clk(clk), .rst_n(rst_b), .bus(if_b.master));
  svc_rv_soc_run_ctrl #(.CYC_W(32), .RST_CYCLES(4), .TIMEOUT(5), .REPORT(1))
    dut_c (.clk(clk), .rst_n(rst_c), .bus(if_c.master));
  svc_rv_soc_run_ctrl #(.CYC_W(32), .RST_CYCLES(4), .TIMEOUT(1048576), .REPORT(0))
    dut_d (.clk(clk), .rst_n(rst_d), .bus(if_d.master));

  // Observation mux onto the selected instance.
  int          sel = 0;
  logic        m_soc_rst_n, m_busy, m_done, m_valid;
  logic [1:0]  m_status;
  logic [31:0] m_cycles;
  logic [7:0]  m_data;

  always_comb begin
    m_soc_rst_n = if_a.soc_rst_n; m_busy = if_a.busy; m_done = if_a.done;
    m_status = if_a.status; m_cycles = if_a.cycles;
    m_valid = if_a.rpt_valid; m_data = if_a.rpt_data;
    case (sel)
      1: begin
        m_soc_rst_n = if_b.soc_rst_n; m_busy = if_b.busy; m_done = if_b.done;
        m_status = if_b.status; m_cycles = if_b.cycles;
        m_valid = if_b.rpt_valid; m_data = if_b.rpt_data;
      end
      2: begin
        m_soc_rst_n = if_c.soc_rst_n; m_busy = if_c.busy; m_done = if_c.done;
        m_status = if_c.status; m_cycles = if_c.cycles;
        m_valid = if_c.rpt_valid; m_data = if_c.rpt_data;
      end
      3: begin
        m_soc_rst_n = if_d.soc_rst_n; m_busy = if_d.busy; m_done = if_d.done;
        m_status = if_d.status; m_cycles = if_d.cycles;
        m_valid = if_d.rpt_valid; m_data = if_d.rpt_data;
      end
      default: ;
    endcase
  end

  logic seen_valid_d = 1'b0;
  always @(negedge clk) if (if_d.rpt_valid === 1'b1) seen_valid_d <= 1'b1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int pat[5] = '{0, 1, 0, 0, 1};

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_report(input logic [1:0] st, input logic [31:0] cyc);
    exp_q.push_back({6'b0, st});
    for (int i = 0; i < 4; i++) exp_q.push_back(cyc[8*i +: 8]);
  endtask

  task automatic select_dut(input int which);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    tb_start = 1'b0; tb_ebreak = 1'b0; tb_trap = 1'b0; tb_ready = 1'b0;
    sel = which;
    @(negedge clk); @(negedge clk);
    check("rst_soc_rst_n", 64'(m_soc_rst_n), 64'd0);
    check("rst_busy",      64'(m_busy),      64'd0);
    check("rst_done",      64'(m_done),      64'd0);
    check("rst_status",    64'(m_status),    64'd0);
    check("rst_cycles",    64'(m_cycles),    64'd0);
    check("rst_rpt_valid", 64'(m_valid),     64'd0);
    check("rst_rpt_data",  64'(m_data),      64'd0);
    case (which)
      0: rst_a = 1'b1;
      1: rst_b = 1'b1;
      2: rst_c = 1'b1;
      default: rst_d = 1'b1;
    endcase
    @(negedge clk);
  endtask

  // Start (pulse or level) and measure HOLD length; ends on first RUN cycle.
  task automatic start_run(input bit keep_start);
    int n;
    tb_start = 1'b1;
    @(negedge clk);
    if (!keep_start) tb_start = 1'b0;
    check("hold_busy",      64'(m_busy),      64'd1);
    check("hold_soc_rst_n", 64'(m_soc_rst_n), 64'd0);
    check("hold_done",      64'(m_done),      64'd0);
    n = 0;
    while (m_soc_rst_n !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("hold_len", 64'(n), 64'd4);
  endtask

  // From the first RUN cycle, wait n cycles then raise trap/ebreak.
  task automatic run_stop(input int n, input bit t, input bit e,
                          input bit keep_e, input bit has_rpt);
    logic [1:0] st;
    repeat (n) @(negedge clk);
    check("run_soc_rst_n", 64'(m_soc_rst_n), 64'd1);
    tb_trap = t; tb_ebreak = e;
    st = t ? RUN_ST_TRAP : (e ? RUN_ST_EBREAK : RUN_ST_TIMEOUT);
    if (has_rpt) push_report(st, 32'(n));
    @(negedge clk);
    check("stop_soc_rst_n", 64'(m_soc_rst_n), 64'd0);
    check("stop_status",    64'(m_status),    64'(st));
    check("stop_cycles",    64'(m_cycles),    64'(n));
    check("stop_rpt_valid", 64'(m_valid),     64'(has_rpt));
    check("stop_busy",      64'(m_busy),      64'(has_rpt));
    check("stop_done",      64'(m_done),      64'(!has_rpt));
    tb_trap = 1'b0;
    if (!keep_e) tb_ebreak = 1'b0;
  endtask

  // Drain the report with a ready pattern; mode 0 = always ready.
  task automatic recv(input int mode);
    int k = 0;
    int guard = 0;
    bit stalled = 0;
    logic [7:0] held = 8'h00;
    logic [7:0] exp;
    while (exp_q.size() > 0 && guard < 200) begin
      tb_ready = (mode == 0) ? 1'b1 : (pat[k % 5] != 0);
      k++;
      if (m_valid === 1'b1) begin
        if (stalled) check("rpt_stable", 64'(m_data), 64'(held));
        if (tb_ready) begin
          exp = exp_q.pop_front();
          check("rpt_byte", 64'(m_data), 64'(exp));
          stalled = 0;
        end else begin
          held = m_data;
          stalled = 1;
        end
      end
      @(negedge clk);
      guard++;
    end
    tb_ready = 1'b0;
    check("rpt_drained",   64'(exp_q.size()), 64'd0);
    check("rpt_valid_end", 64'(m_valid),      64'd0);
    check("rpt_done",      64'(m_done),       64'd1);
    check("rpt_busy_end",  64'(m_busy),       64'd0);
    exp_q.delete();
  endtask

  initial begin
    int n;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0; rst_d = 1'b0;
    tb_start = 1'b0; tb_ebreak = 1'b0; tb_trap = 1'b0; tb_ready = 1'b0;

    // 1: ebreak after 10 RUN cycles
    select_dut(0);
    start_run(0);
    run_stop(10, 0, 1, 0, 1);
    recv(0);

    // 3a: trap and ebreak together -> trap wins
    start_run(0);
    run_stop(5, 1, 1, 0, 1);
    recv(0);

    // 4: stalled report, ebreak at 300
    start_run(0);
    run_stop(300, 0, 1, 0, 1);
    recv(1);

    // 5: reset during RUN cycle 7
    start_run(0);
    repeat (7) @(negedge clk);
    rst_a = 1'b0;
    @(negedge clk);
    check("abort_soc_rst_n", 64'(m_soc_rst_n), 64'd0);
    check("abort_rpt_valid", 64'(m_valid),     64'd0);
    check("abort_status",    64'(m_status),    64'd0);
    check("abort_cycles",    64'(m_cycles),    64'd0);
    check("abort_busy",      64'(m_busy),      64'd0);
    rst_a = 1'b1;
    @(negedge clk);
    // start held as a level through HOLD and RUN is ignored
    start_run(1);
    run_stop(6, 0, 1, 1, 1);
    tb_start = 1'b0;
    recv(0);
    // stale ebreak in DONE ignored
    repeat (5) @(negedge clk);
    check("done_hold",        64'(m_done),      64'd1);
    check("done_status",      64'(m_status),    64'(RUN_ST_EBREAK));
    check("done_cycles",      64'(m_cycles),    64'd6);
    check("done_soc_rst_n",   64'(m_soc_rst_n), 64'd0);
    // restart with ebreak still high -> stops on first RUN cycle
    start_run(0);
    run_stop(0, 0, 1, 0, 1);
    recv(0);

    // 2: timeout at 16
    select_dut(1);
    push_report(RUN_ST_TIMEOUT, 32'd16);
    start_run(0);
    n = 0;
    while (m_soc_rst_n === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("to_run_len",   64'(n),        64'd17);
    check("to_status",    64'(m_status), 64'(RUN_ST_TIMEOUT));
    check("to_cycles",    64'(m_cycles), 64'd16);
    check("to_rpt_valid", 64'(m_valid),  64'd1);
    recv(0);

    // 3b: ebreak coincident with timeout at 5 -> ebreak wins
    select_dut(2);
    start_run(0);
    run_stop(5, 0, 1, 0, 1);
    recv(0);

    // 6: no report
    select_dut(3);
    start_run(0);
    run_stop(3, 0, 1, 0, 0);
    repeat (3) @(negedge clk);
    check("norpt_done",       64'(m_done),       64'd1);
    check("norpt_cycles",     64'(m_cycles),     64'd3);
    check("norpt_never_valid", 64'(seen_valid_d), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/svc_rv_soc_run_ctrl.md
Name: svc_rv_soc_run_ctrl

Overview:
Run sequencer for an svc_rv_soc_sram instance.
- Holds the SoC in reset, releases it on a start request, and counts execution cycles until ebreak, trap or timeout.
- Returns the SoC to reset and emits a byte-stream report (status plus cycle count) over a valid/ready interface.
- Sits between top-level test/demo logic and the SoC's rst_n/ebreak/trap pins; gives CPI-style measurements without a debugger.

Parameters:
CYC_W, 32, cycle counter width; must be a multiple of 8, range 8..64.
RST_CYCLES, 4, cycles soc_rst_n is held low after start; must be >= 1.
TIMEOUT, 1048576, maximum RUN cycles before forced stop; 0 disables timeout.
REPORT, 1, 1 = emit report bytes; 0 = skip REPORT state (rpt_valid tied 0).

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
start  in  1  run request; single-cycle pulse or level
soc_ebreak  in  1  SoC ebreak indication
soc_trap  in  1  SoC trap indication
soc_rst_n  out  1  registered reset to SoC, active-low
busy  out  1  high in HOLD, RUN, REPORT
done  out  1  high in DONE state (level)
status  out  2  0 none, 1 ebreak, 2 trap, 3 timeout
cycles  out  CYC_W  latched RUN cycle count of last run
rpt_valid  out  1  report byte valid
rpt_data  out  8  report byte
rpt_ready  in  1  report byte accepted

Behaviour:
- Reset (rst_n=0 at posedge) is synchronous.
  - State goes to IDLE.
  - Output values: soc_rst_n=0, busy=0, done=0, status=0, cycles=0, rpt_valid=0, rpt_data=0.
  - Reset mid-run aborts immediately. No report is emitted.
- All outputs are registered.
- States: IDLE, HOLD, RUN, REPORT, DONE.
- IDLE or DONE, start=1:
  - Go to HOLD. Clear the hold counter.
  - soc_rst_n stays 0. status and cycles are preserved until RUN exits.
- start in HOLD, RUN or REPORT is ignored.
- HOLD:
  - Lasts exactly RST_CYCLES cycles.
  - On the final HOLD edge, go to RUN and set soc_rst_n=1. The run counter is cleared to 0 on the same edge.
- RUN:
  - Each cycle, sample soc_trap, soc_ebreak and the timeout condition with priority trap > ebreak > timeout.
  - If none is active, the counter increments, saturating at all-ones.
  - On stop, the same edge latches status and sets cycles=counter (not incremented).
    - Ebreak sampled on the first RUN cycle gives cycles=0.
  - On stop, soc_rst_n returns to 0 on the same edge. Next state is REPORT if REPORT=1, else DONE.
- Timeout:
  - When TIMEOUT!=0 and counter==TIMEOUT with no trap/ebreak that cycle: status=3, cycles=TIMEOUT.
  - Ebreak arriving in the same cycle as the timeout condition wins (status=1).
- REPORT:
  - Sends 1+CYC_W/8 bytes.
    - Byte 0 = {6'b0, status}.
    - Then cycles, LSB first.
  - rpt_valid=1 throughout REPORT.
  - rpt_data is held stable while rpt_valid && !rpt_ready; it advances on each accepted byte.
  - After the last byte is accepted: rpt_valid=0, go to DONE.
  - No timeout while waiting on rpt_ready.
- DONE:
  - done=1, soc_rst_n=0. status and cycles remain readable.
  - start begins a new run and clears done on the same edge.
- Soc inputs are ignored outside RUN. This covers stale ebreak held high from a previous run.
- Byte index counter width is $clog2(CYC_W/8+1). Hold counter width is $clog2(RST_CYCLES+1).

Decomposition:
- Shared package svc_rv_soc_run_pkg holds:
  - state enum run_state_t (IDLE, HOLD, RUN, REPORT, DONE).
  - status codes RUN_ST_NONE=0, RUN_ST_EBREAK=1, RUN_ST_TRAP=2, RUN_ST_TIMEOUT=3.
- One natural sub-module: svc_rv_soc_run_rpt_ser, a word-to-byte valid/ready serializer with inputs load, status, cycles.
  - Keeps the handshake logic separate from the sequencing FSM.

Test Plan:
1. Default params: start pulse; ebreak asserted 10 cycles after soc_rst_n rises -> soc_rst_n low exactly 4 cycles after start; status=1, cycles=10; report bytes 0x01,0x0A,0x00,0x00,0x00; done=1.
2. TIMEOUT=16, no ebreak -> stop after 16 RUN cycles; status=3, cycles=16; soc_rst_n=0 on the stop edge.
3. trap and ebreak both high on RUN cycle 5 -> status=2, cycles=5; ebreak coincident with timeout (TIMEOUT=5) -> status=1, cycles=5.
4. rpt_ready toggled 0,1,0,0,1,... with ebreak at 300 -> rpt_data stable while stalled; bytes 0x01,0x2C,0x01,0x00,0x00 in order, none duplicated or dropped.
5. rst_n asserted during RUN cycle 7 -> next edge: IDLE, soc_rst_n=0, rpt_valid=0, status=0, cycles=0; start during HOLD or RUN ignored; soc_ebreak held high in DONE, then restart -> first run completes normally, and the restart's first RUN cycle with soc_ebreak still high ends with cycles=0.
6. REPORT=0, ebreak at 3 -> direct RUN->DONE; rpt_valid never asserts; cycles=3.
